bank_read_gather: RTL and testbench
===================================

Name: bank_read_gather

Overview:
- Return-path counterpart of the lane-to-bank scatter arbiter in the multi-lane NTT memory subsystem.
- The scatter side routes each lane's request to its bank, bank slot b receiving lane index i where BI[i]=b. This block does the reverse on reads.
- It captures the per-lane bank map at request time and delays it to match the bank read latency. It then gathers each bank's read data back to the lane that requested it, with a registered output and a valid strobe.
- It also flags bank conflicts and out-of-range bank indices per beat.

Parameters:
- N, 8, number of lanes = number of banks; instantiated as 2*`P.
- W, 16, data width per bank/lane.
- SELW, 3, bank index width; instantiated as `MAP. Must satisfy 2^SELW >= N.
- RD_LAT, 2, bank read latency in cycles from request to rdata valid. Legal range 1..4.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  read request beat issued to banks this cycle
- BI_bus  in  N*SELW  per-lane bank index; lane i occupies bits [i*SELW +: SELW]
- bank_rdata_bus  in  N*W  bank read data; bank b occupies bits [b*W +: W]; valid RD_LAT cycles after the request
- clr_err  in  1  clears sticky error flags
- out_valid  out  1  gathered beat valid
- lane_rdata_bus  out  N*W  gathered data; lane i occupies bits [i*W +: W]
- out_BI_bus  out  N*SELW  bank map of the beat being output, delayed copy
- beat_conflict  out  1  the current out beat had two or more lanes on one bank
- beat_range_err  out  1  the current out beat had some BI[i] >= N
- err_sticky  out  1  OR of all beat errors since reset or clr_err

Behaviour:
- Reset (rst_n=0 at posedge) zeroes all outputs: out_valid, lane_rdata_bus, out_BI_bus, beat_conflict, beat_range_err, err_sticky.
- Reset also clears every valid bit in the delay line. In-flight beats are dropped and never emerge.
- Delay line: RD_LAT-stage shift register of {req_valid, BI_bus, conflict_bit, range_bit}. It advances every cycle; there is no stall or backpressure.
- conflict_bit is computed combinationally at request time: any pair i<j with BI[i]==BI[j], considering only in-range indices.
- range_bit is computed at request time: any BI[i] >= N.
- Gather stage, at the cycle when stage RD_LAT of the delay line is valid: for lane i, lane_rdata[i] = bank_rdata[BI_d[i]] if BI_d[i] < N, otherwise 0.
- The gather result is registered, giving total latency req_valid -> out_valid = RD_LAT+1 cycles.
- out_valid is a single-cycle pulse per request beat. Back-to-back requests produce back-to-back out_valid pulses; throughput is 1 beat per cycle.
- When the delay-line head is invalid: out_valid=0. lane_rdata_bus, out_BI_bus and the beat flags hold their previous values; consumers qualify with out_valid.
- On a conflict beat, lanes sharing a bank all receive that bank's data, which is deterministic. beat_conflict=1 with that out_valid.
- err_sticky sets on the cycle out_valid=1 with beat_conflict or beat_range_err.
- clr_err clears err_sticky next cycle. If clr_err and a new error beat coincide, set wins.
- bank_rdata_bus is sampled only in the gather cycle; values in other cycles are ignored.
- Identity check: if BI is a permutation and bank b returns the data for the lane mapped to it, lane_rdata equals the written lane order. This inverts the scatter.

Test Plan:
- Reset and latency, with N=8, W=16, RD_LAT=2: req_valid at cycle 0 with BI={7,6,5,4,3,2,1,0}. At cycle 2 drive bank b data 0x100+b. Required: out_valid=1 at cycle 3, lane i = 0x107-i, no flags.
- Back-to-back streaming: 4 consecutive beats, each a distinct rotation BI[i]=(i+k)%8 for k=0..3. Required: 4 consecutive out_valid pulses, lane i data = bank (i+k)%8 data per beat, in order.
- Conflict: BI={0,0,2,3,4,5,6,7}, bank0 data 0xAAAA. Required: lanes 0 and 1 both 0xAAAA, beat_conflict=1, err_sticky=1 from the next cycle.
- Range error (SELW=4, N=8): lane 3 BI=9. Required: lane 3 data=0, beat_range_err=1, other lanes correct. clr_err pulse clears err_sticky; a clr_err coincident with a new error beat leaves it set.
- Reset mid-flight: req_valid at cycle 0, rst_n=0 at cycle 1 for 1 cycle. Required: no out_valid at cycle 3, all outputs 0 after reset.
- Gaps: requests at cycles 0 and 3 only. Required: out_valid at cycles 3 and 6 only; outputs hold the first beat's values during cycles 4-5.

Source files
------------

// File: rtl/bank_read_gather_if.sv
// Bundle of the bank read-gather signals.
// The master side issues read beats, carries the bank read data and the error
// clear, and receives the gathered beat. The slave side is the gather block.
//   req_valid       read beat issued to the banks this cycle
//   BI_bus          per-lane bank index, lane i at [i*SELW +: SELW]
//   bank_rdata_bus  bank read data, bank b at [b*W +: W]
//   clr_err         clears the sticky error flag
//   out_valid       gathered beat valid (single-cycle pulse)
//   lane_rdata_bus  gathered data, lane i at [i*W +: W]
//   out_BI_bus      bank map belonging to the output beat
//   beat_conflict   output beat had two lanes on one bank
//   beat_range_err  output beat had a bank index >= N
//   err_sticky      OR of beat errors since reset or clr_err
interface bank_read_gather_if #(
   parameter int N    = 8,
   parameter int W    = 16,
   parameter int SELW = 3
);
   logic              req_valid;
   logic [N*SELW-1:0] BI_bus;
   logic [N*W-1:0]    bank_rdata_bus;
   logic              clr_err;
   logic              out_valid;
   logic [N*W-1:0]    lane_rdata_bus;
   logic [N*SELW-1:0] out_BI_bus;
   logic              beat_conflict;
   logic              beat_range_err;
   logic              err_sticky;

   modport master (
      output req_valid, BI_bus, bank_rdata_bus, clr_err,
      input  out_valid, lane_rdata_bus, out_BI_bus,
             beat_conflict, beat_range_err, err_sticky
   );

   modport slave (
      input  req_valid, BI_bus, bank_rdata_bus, clr_err,
      output out_valid, lane_rdata_bus, out_BI_bus,
             beat_conflict, beat_range_err, err_sticky
   );
endinterface

// File: rtl/bank_read_gather.sv
// Return path of the lane-to-bank scatter: the bank map of each read beat is
// captured at request time, delayed by the bank read latency, and used to
// route every bank's read data back to the lane that asked for it.
// Ports:
//   clk    clock
//   rst_n  synchronous active-low reset
//   bus    bank_read_gather_if.slave (request, bank data, gathered output,
//          per-beat conflict / range flags and sticky error)
module bank_read_gather #(
   parameter int N      = 8,
   parameter int W      = 16,
   parameter int SELW   = 3,
   parameter int RD_LAT = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   bank_read_gather_if.slave    bus
);

   localparam int H = RD_LAT - 1;
   // N widened by one bit so "index >= N" stays meaningful when 2^SELW == N.
   localparam logic [SELW:0] N_X = (SELW + 1)'(N);

   logic              conflict_in;
   logic              range_in;

   logic              vld_q   [RD_LAT];
   logic              vld_d   [RD_LAT];
   logic [N*SELW-1:0] bi_q    [RD_LAT];
   logic [N*SELW-1:0] bi_d    [RD_LAT];
   logic              cf_q    [RD_LAT];
   logic              cf_d    [RD_LAT];
   logic              rg_q    [RD_LAT];
   logic              rg_d    [RD_LAT];

   logic              out_valid_q,      out_valid_d;
   logic signed [N*W-1:0] lane_rdata_q, lane_rdata_d;
   logic [N*SELW-1:0] out_bi_q,         out_bi_d;
   logic              beat_conflict_q,  beat_conflict_d;
   logic              beat_range_err_q, beat_range_err_d;
   logic              err_sticky_q,     err_sticky_d;

   // Request stage: flag the beat while its map is on the bus.
   always_comb begin
      conflict_in = 1'b0;
      range_in    = 1'b0;
      for (int i = 0; i < N; i++) begin
         if ({1'b0, bus.BI_bus[i*SELW +: SELW]} >= N_X) range_in = 1'b1;
         for (int j = i + 1; j < N; j++) begin
            if ((bus.BI_bus[i*SELW +: SELW] == bus.BI_bus[j*SELW +: SELW]) &&
                ({1'b0, bus.BI_bus[i*SELW +: SELW]} < N_X))
               conflict_in = 1'b1;
         end
      end
   end

   // Delay line: free-running shift, aligns the map with bank read data.
   always_comb begin
      vld_d[0] = bus.req_valid;
      bi_d[0]  = bus.BI_bus;
      cf_d[0]  = conflict_in;
      rg_d[0]  = range_in;
      for (int s = 1; s < RD_LAT; s++) begin
         vld_d[s] = vld_q[s-1];
         bi_d[s]  = bi_q[s-1];
         cf_d[s]  = cf_q[s-1];
         rg_d[s]  = rg_q[s-1];
      end
   end

   // Gather stage: head of the delay line selects a bank per lane.
   always_comb begin
      out_valid_d      = vld_q[H];
      lane_rdata_d     = lane_rdata_q;
      out_bi_d         = out_bi_q;
      beat_conflict_d  = beat_conflict_q;
      beat_range_err_d = beat_range_err_q;
      if (vld_q[H]) begin
         out_bi_d         = bi_q[H];
         beat_conflict_d  = cf_q[H];
         beat_range_err_d = rg_q[H];
         for (int i = 0; i < N; i++) begin
            // Out-of-range indices match no bank and leave the lane at zero.
            lane_rdata_d[i*W +: W] = '0;
            for (int b = 0; b < N; b++) begin
               if (bi_q[H][i*SELW +: SELW] == SELW'(b))
                  lane_rdata_d[i*W +: W] = bus.bank_rdata_bus[b*W +: W];
            end
         end
      end
      // Set from the registered beat flags wins over a coincident clear.
      err_sticky_d = (out_valid_q & (beat_conflict_q | beat_range_err_q)) |
                     (err_sticky_q & ~bus.clr_err);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int s = 0; s < RD_LAT; s++) vld_q[s] <= 1'b0;
         out_valid_q      <= 1'b0;
         lane_rdata_q     <= '0;
         out_bi_q         <= '0;
         beat_conflict_q  <= 1'b0;
         beat_range_err_q <= 1'b0;
         err_sticky_q     <= 1'b0;
      end else begin
         vld_q            <= vld_d;
         out_valid_q      <= out_valid_d;
         lane_rdata_q     <= lane_rdata_d;
         out_bi_q         <= out_bi_d;
         beat_conflict_q  <= beat_conflict_d;
         beat_range_err_q <= beat_range_err_d;
         err_sticky_q     <= err_sticky_d;
      end
   end

   // Map and flags in flight are qualified by vld_q, so they need no reset.
   always_ff @(posedge clk) begin
      bi_q <= bi_d;
      cf_q <= cf_d;
      rg_q <= rg_d;
   end

   assign bus.out_valid      = out_valid_q;
   assign bus.lane_rdata_bus = lane_rdata_q;
   assign bus.out_BI_bus     = out_bi_q;
   assign bus.beat_conflict  = beat_conflict_q;
   assign bus.beat_range_err = beat_range_err_q;
   assign bus.err_sticky     = err_sticky_q;

endmodule

// File: tb/tb_bank_read_gather.sv
// Bench for bank_read_gather with N=8, W=16, SELW=4, RD_LAT=2.
module tb_bank_read_gather;
   localparam int N = 8;
   localparam int W = 16;
   localparam int SELW = 4;
   localparam int L = 2;

   logic clk;
   logic rst_n;
   int   cyc;
   int   n_checks;
   int   n_err;

   bank_read_gather_if #(.N(N), .W(W), .SELW(SELW)) bif ();

   bank_read_gather #(.N(N), .W(W), .SELW(SELW), .RD_LAT(L)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bif)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("FAIL watchdog at cycle %0d: got timeout expected finish", cyc);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] mk(input logic [15:0] base);
      logic [127:0] v;
      for (int b = 0; b < N; b++) v[b*16 +: 16] = 16'(base + 16'(b));
      return v;
   endfunction

   function automatic logic [127:0] rnd();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [31:0] rot(input int k);
      logic [31:0] v;
      for (int i = 0; i < N; i++) v[i*4 +: 4] = 4'((i + k) % N);
      return v;
   endfunction

   // ---------------- reference model: history of inputs per cycle ----------
   logic         req_h  [0:1023];
   logic [31:0]  bi_h   [0:1023];
   logic [127:0] bank_h [0:1023];
   logic         clr_h  [0:1023];
   logic         rst_h  [0:1023];

   logic         e_vld, e_cf, e_rg, e_sticky;
   logic [127:0] e_lane;
   logic [31:0]  e_bi;

   initial begin
      e_vld = 0; e_cf = 0; e_rg = 0; e_sticky = 0; e_lane = '0; e_bi = '0;
   end

   always @(negedge clk) begin
      logic         ns, beat;
      logic [31:0]  bv;
      logic [127:0] bk;
      int           r, sel, sj;
      req_h[cyc]  = bif.req_valid;
      bi_h[cyc]   = bif.BI_bus;
      bank_h[cyc] = bif.bank_rdata_bus;
      clr_h[cyc]  = bif.clr_err;
      rst_h[cyc]  = !rst_n;
      if (cyc >= 2) begin
         if (rst_h[cyc-1]) begin
            e_vld = 0; e_cf = 0; e_rg = 0; e_sticky = 0; e_lane = '0; e_bi = '0;
         end else begin
            ns = (e_vld && (e_cf || e_rg)) || (e_sticky && !clr_h[cyc-1]);
            r = cyc - L - 1;
            beat = 0;
            if (r >= 1 && req_h[r]) begin
               beat = 1;
               for (int k = r; k < cyc; k++) if (rst_h[k]) beat = 0;
            end
            e_vld = beat;
            e_sticky = ns;
            if (beat) begin
               bv = bi_h[r];
               bk = bank_h[r + L];
               e_bi = bv;
               e_cf = 0;
               e_rg = 0;
               for (int i = 0; i < N; i++) begin
                  sel = int'(bv[i*4 +: 4]);
                  if (sel < N) e_lane[i*16 +: 16] = bk[sel*16 +: 16];
                  else begin
                     e_lane[i*16 +: 16] = 16'h0;
                     e_rg = 1;
                  end
                  for (int j = i + 1; j < N; j++) begin
                     sj = int'(bv[j*4 +: 4]);
                     if (sel < N && sj == sel) e_cf = 1;
                  end
               end
            end
         end
         chk("m_out_valid", 128'(bif.out_valid), 128'(e_vld));
         chk("m_lane_rdata", 128'(bif.lane_rdata_bus), e_lane);
         chk("m_out_bi", 128'(bif.out_BI_bus), 128'(e_bi));
         chk("m_conflict", 128'(bif.beat_conflict), 128'(e_cf));
         chk("m_range", 128'(bif.beat_range_err), 128'(e_rg));
         chk("m_sticky", 128'(bif.err_sticky), 128'(e_sticky));
      end
   end

   // ---------------- directed stimulus with literal expectations -----------
   initial begin
      n_checks = 0;
      n_err = 0;
      rst_n = 1'b0;
      bif.req_valid = 1'b0;
      bif.BI_bus = '0;
      bif.bank_rdata_bus = '0;
      bif.clr_err = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      chk("rst_out_valid", 128'(bif.out_valid), 128'(1'b0));
      chk("rst_lane", 128'(bif.lane_rdata_bus), 128'(0));
      chk("rst_sticky", 128'(bif.err_sticky), 128'(1'b0));

      // reversal map, latency RD_LAT+1
      bif.req_valid = 1'b1; bif.BI_bus = 32'h01234567; bif.bank_rdata_bus = rnd();
      step();
      bif.req_valid = 1'b0; bif.bank_rdata_bus = rnd();
      step();
      chk("lat_early", 128'(bif.out_valid), 128'(1'b0));
      bif.bank_rdata_bus = mk(16'h100);
      step();
      bif.bank_rdata_bus = rnd();
      chk("lat_valid", 128'(bif.out_valid), 128'(1'b1));
      chk("lat_lane0", 128'(bif.lane_rdata_bus[15:0]), 128'(16'h107));
      chk("lat_lane7", 128'(bif.lane_rdata_bus[127:112]), 128'(16'h100));
      chk("lat_flags", 128'({bif.beat_conflict, bif.beat_range_err}), 128'(2'b00));
      step();
      chk("lat_pulse", 128'(bif.out_valid), 128'(1'b0));

      // back-to-back rotations
      for (int t = 0; t < 8; t++) begin
         bif.req_valid = (t < 4);
         bif.BI_bus = rot(t % 4);
         bif.bank_rdata_bus = (t >= 2 && t < 6) ? mk(16'(16'h200 + 16 * (t - 2))) : rnd();
         if (t >= 3 && t < 7) begin
            chk("b2b_valid", 128'(bif.out_valid), 128'(1'b1));
            chk("b2b_lane0", 128'(bif.lane_rdata_bus[15:0]), 128'(16'(16'h200 + 17 * (t - 3))));
         end
         if (t == 7) chk("b2b_end", 128'(bif.out_valid), 128'(1'b0));
         step();
      end
      bif.req_valid = 1'b0;

      // conflict: lanes 0 and 1 on bank 0
      bif.req_valid = 1'b1; bif.BI_bus = 32'h76543200; bif.bank_rdata_bus = rnd();
      step();
      bif.req_valid = 1'b0;
      step();
      bif.bank_rdata_bus = mk(16'h300);
      bif.bank_rdata_bus[15:0] = 16'hAAAA;
      step();
      bif.bank_rdata_bus = rnd();
      chk("cf_lane0", 128'(bif.lane_rdata_bus[15:0]), 128'(16'hAAAA));
      chk("cf_lane1", 128'(bif.lane_rdata_bus[31:16]), 128'(16'hAAAA));
      chk("cf_lane2", 128'(bif.lane_rdata_bus[47:32]), 128'(16'h302));
      chk("cf_flag", 128'(bif.beat_conflict), 128'(1'b1));
      chk("cf_sticky_same", 128'(bif.err_sticky), 128'(1'b0));
      step();
      chk("cf_sticky_next", 128'(bif.err_sticky), 128'(1'b1));

      // range error on lane 3, then clears
      bif.clr_err = 1'b1;
      step();
      bif.clr_err = 1'b0;
      chk("clr_sticky", 128'(bif.err_sticky), 128'(1'b0));
      bif.req_valid = 1'b1; bif.BI_bus = 32'h76549210;
      step();
      bif.req_valid = 1'b0;
      step();
      bif.bank_rdata_bus = mk(16'h400);
      step();
      bif.bank_rdata_bus = rnd();
      chk("rg_lane3", 128'(bif.lane_rdata_bus[63:48]), 128'(16'h0));
      chk("rg_lane2", 128'(bif.lane_rdata_bus[47:32]), 128'(16'h402));
      chk("rg_lane4", 128'(bif.lane_rdata_bus[79:64]), 128'(16'h404));
      chk("rg_flag", 128'(bif.beat_range_err), 128'(1'b1));
      chk("rg_no_cf", 128'(bif.beat_conflict), 128'(1'b0));
      step();
      chk("rg_sticky", 128'(bif.err_sticky), 128'(1'b1));
      bif.clr_err = 1'b1;
      step();
      bif.clr_err = 1'b0;
      chk("rg_clr", 128'(bif.err_sticky), 128'(1'b0));
      // clear coincident with a new error beat: set wins
      bif.req_valid = 1'b1; bif.BI_bus = 32'h76549210;
      step();
      bif.req_valid = 1'b0;
      step();
      bif.bank_rdata_bus = mk(16'h480);
      step();
      bif.bank_rdata_bus = rnd();
      bif.clr_err = 1'b1;
      chk("co_valid", 128'(bif.out_valid), 128'(1'b1));
      step();
      bif.clr_err = 1'b0;
      chk("co_sticky", 128'(bif.err_sticky), 128'(1'b1));
      bif.clr_err = 1'b1;
      step();
      bif.clr_err = 1'b0;

      // reset while a beat is in flight
      bif.req_valid = 1'b1; bif.BI_bus = 32'h76543210;
      step();
      bif.req_valid = 1'b0; rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("mid_valid", 128'(bif.out_valid), 128'(1'b0));
      chk("mid_lane", 128'(bif.lane_rdata_bus), 128'(0));
      chk("mid_bi", 128'(bif.out_BI_bus), 128'(0));
      chk("mid_sticky", 128'(bif.err_sticky), 128'(1'b0));
      step();
      chk("mid_dropped", 128'(bif.out_valid), 128'(1'b0));
      step();

      // gaps: requests 3 cycles apart, outputs hold in between
      bif.req_valid = 1'b1; bif.BI_bus = 32'h76543210;
      step();
      bif.req_valid = 1'b0;
      step();
      bif.bank_rdata_bus = mk(16'h500);
      step();
      bif.req_valid = 1'b1; bif.BI_bus = rot(1); bif.bank_rdata_bus = rnd();
      chk("gap_v1", 128'(bif.out_valid), 128'(1'b1));
      chk("gap_l1", 128'(bif.lane_rdata_bus[15:0]), 128'(16'h500));
      step();
      bif.req_valid = 1'b0;
      chk("gap_hold_v", 128'(bif.out_valid), 128'(1'b0));
      chk("gap_hold_l", 128'(bif.lane_rdata_bus[15:0]), 128'(16'h500));
      step();
      bif.bank_rdata_bus = mk(16'h600);
      chk("gap_hold_bi", 128'(bif.out_BI_bus), 128'(32'h76543210));
      step();
      bif.bank_rdata_bus = rnd();
      chk("gap_v2", 128'(bif.out_valid), 128'(1'b1));
      chk("gap_l2", 128'(bif.lane_rdata_bus[15:0]), 128'(16'h601));
      step();
      chk("gap_end", 128'(bif.out_valid), 128'(1'b0));
      step();
      step();
      #2;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
